// File: rtl/gpio_port_pcint.sv
// AVR-style GPIO port: PORT/DDR/PCMSK registers, synchronised PIN readback, PIN-write toggle,
// pin-change flag/IRQ. Optional per-bit glitch filter enabled by defining GPIO_PORT_FILTER_EN.
module gpio_port_pcint #(
    parameter int                 p_width     = 8,
    parameter logic [p_width-1:0] p_port_init = '0,
    parameter logic [p_width-1:0] p_impl_mask = '1,
    parameter int                 p_filt_len  = 3
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic [1:0]         sel,
    input  logic               wbe,
    input  logic [p_width-1:0] wdata,
    output logic [p_width-1:0] rdata,
    input  logic [p_width-1:0] pin_in,
    output logic [p_width-1:0] port_out,
    output logic [p_width-1:0] ddr_out,
    input  logic               pc_ack,
    output logic               pc_flag,
    output logic               pc_irq
);

    localparam logic [p_width-1:0] c_mask = p_impl_mask;
    localparam logic [p_width-1:0] c_init = p_port_init & p_impl_mask;

    if (p_width < 1 || p_width > 16) begin : g_bad_width
        $error("gpio_port_pcint: p_width out of range");
    end
    if (p_filt_len < 2 || p_filt_len > 15) begin : g_bad_filt
        $error("gpio_port_pcint: p_filt_len out of range");
    end

    logic [p_width-1:0] r_port;
    logic [p_width-1:0] r_ddr;
    logic [p_width-1:0] r_pcmsk;
    logic [p_width-1:0] r_sync1;
    logic [p_width-1:0] r_sync2;
    logic [p_width-1:0] r_pin_s;
    logic [p_width-1:0] r_pin_q;
    logic               r_flag;
    logic [p_width-1:0] w_chg;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_port  <= c_init;
            r_ddr   <= '0;
            r_pcmsk <= '0;
        end else if (wbe) begin
            case (sel)
                2'd0:    r_port  <= r_port ^ (wdata & c_mask);
                2'd1:    r_ddr   <= wdata & c_mask;
                2'd2:    r_port  <= wdata & c_mask;
                default: r_pcmsk <= wdata & c_mask;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= pin_in;
            r_sync2 <= r_sync1;
        end
    end

`ifdef GPIO_PORT_FILTER_EN
    localparam logic [3:0] c_stable = 4'(p_filt_len - 1);

    // Candidate must be seen p_filt_len consecutive cycles before it reaches pin_s.
    for (genvar i = 0; i < p_width; i++) begin : g_filt
        logic       r_cand;
        logic [3:0] r_cnt;

        always_ff @(posedge clk or negedge nrst) begin
            if (!nrst) begin
                r_cand     <= 1'b0;
                r_cnt      <= 4'd0;
                r_pin_s[i] <= 1'b0;
            end else if (r_sync2[i] != r_cand) begin
                r_cand <= r_sync2[i];
                r_cnt  <= 4'd1;
            end else if (r_cnt == c_stable) begin
                r_pin_s[i] <= r_cand;
            end else begin
                r_cnt <= r_cnt + 4'd1;
            end
        end
    end
`else
    always_comb r_pin_s = r_sync2;
`endif

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_pin_q <= '0;
        end else begin
            r_pin_q <= r_pin_s;
        end
    end

    assign w_chg = (r_pin_s ^ r_pin_q) & r_pcmsk & c_mask;

    // A change in the ack cycle keeps the flag set so no event is lost.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_flag <= 1'b0;
        end else if (|w_chg) begin
            r_flag <= 1'b1;
        end else if (pc_ack) begin
            r_flag <= 1'b0;
        end
    end

    always_comb begin
        rdata = '0;
        case (sel)
            2'd0:    rdata = r_pin_s & c_mask;
            2'd1:    rdata = r_ddr;
            2'd2:    rdata = r_port;
            default: rdata = r_pcmsk;
        endcase
    end

    assign port_out = r_port;
    assign ddr_out  = r_ddr;
    assign pc_flag  = r_flag;
    assign pc_irq   = r_flag;

endmodule

// File: tb/tb_gpio_port_pcint.sv
// Directed bench for gpio_port_pcint: register vector table plus hand-written pin-change sequences.
module tb_gpio_port_pcint;

`ifdef GPIO_PORT_FILTER_EN
    localparam int LAT = 2 + 3;
`else
    localparam int LAT = 2;
`endif

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic [1:0] sel = 2'd0;
    logic       wbe = 1'b0;
    logic [7:0] wdata = 8'h00;
    logic [7:0] rdata;
    logic [7:0] pin_in = 8'h00;
    logic [7:0] port_out;
    logic [7:0] ddr_out;
    logic       pc_ack = 1'b0;
    logic       pc_flag;
    logic       pc_irq;

    int n_checks = 0;
    int n_errors = 0;

    gpio_port_pcint #(
        .p_width     (8),
        .p_port_init (8'hA5),
        .p_impl_mask (8'h7F),
        .p_filt_len  (3)
    ) dut (
        .clk      (clk),
        .nrst     (nrst),
        .sel      (sel),
        .wbe      (wbe),
        .wdata    (wdata),
        .rdata    (rdata),
        .pin_in   (pin_in),
        .port_out (port_out),
        .ddr_out  (ddr_out),
        .pc_ack   (pc_ack),
        .pc_flag  (pc_flag),
        .pc_irq   (pc_irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] wsel;
        logic [7:0] wd;
        logic [1:0] rsel;
        logic [7:0] exp_rd;
        logic [7:0] exp_port;
        logic [7:0] exp_ddr;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [1:0] s, input logic [7:0] d);
        @(negedge clk);
        sel   = s;
        wbe   = 1'b1;
        wdata = d;
        @(posedge clk);
        #1 wbe = 1'b0;
    endtask

    task automatic ack_cycle();
        @(negedge clk);
        pc_ack = 1'b1;
        @(posedge clk);
        #1 pc_ack = 1'b0;
    endtask

    initial begin
        // mask 7F, PORT init A5 & 7F = 25
        vecs[0] = '{2'd2, 8'h3C, 2'd2, 8'h3C, 8'h3C, 8'h00};
        vecs[1] = '{2'd0, 8'h0F, 2'd2, 8'h33, 8'h33, 8'h00};
        vecs[2] = '{2'd0, 8'h00, 2'd2, 8'h33, 8'h33, 8'h00};
        vecs[3] = '{2'd1, 8'hFF, 2'd1, 8'h7F, 8'h33, 8'h7F};
        vecs[4] = '{2'd2, 8'hFF, 2'd2, 8'h7F, 8'h7F, 8'h7F};
        vecs[5] = '{2'd0, 8'h80, 2'd2, 8'h7F, 8'h7F, 8'h7F};
        vecs[6] = '{2'd0, 8'hFF, 2'd2, 8'h00, 8'h00, 8'h7F};
        vecs[7] = '{2'd3, 8'h81, 2'd3, 8'h01, 8'h00, 8'h7F};
        vecs[8] = '{2'd1, 8'h00, 2'd1, 8'h00, 8'h00, 8'h00};

        #12;
        sel = 2'd2;
        #1;
        check("rst_port_out", 16'(port_out), 16'h25);
        check("rst_ddr_out", 16'(ddr_out), 16'h00);
        check("rst_irq", 16'(pc_irq), 16'h0);
        check("rst_rdata_port", 16'(rdata), 16'h25);
        @(negedge clk);
        nrst = 1'b1;

        for (int i = 0; i < 9; i++) begin
            wr(vecs[i].wsel, vecs[i].wd);
            sel = vecs[i].rsel;
            #1;
            check($sformatf("vec%0d_rdata", i), 16'(rdata), 16'(vecs[i].exp_rd));
            check($sformatf("vec%0d_port", i), 16'(port_out), 16'(vecs[i].exp_port));
            check($sformatf("vec%0d_ddr", i), 16'(ddr_out), 16'(vecs[i].exp_ddr));
            check($sformatf("vec%0d_flag", i), 16'(pc_flag), 16'h0);
        end

        // PIN synchroniser latency and masked readback; PCMSK=01 so bit0 rise flags
        @(negedge clk);
        sel    = 2'd0;
        pin_in = 8'hFF;
        repeat (LAT - 1) @(posedge clk);
        #1 check("pin_early", 16'(rdata), 16'h00);
        @(posedge clk);
        #1 check("pin_sync", 16'(rdata), 16'h7F);
        check("flag_not_yet", 16'(pc_flag), 16'h0);
        @(posedge clk);
        #1 check("flag_set", 16'(pc_flag), 16'h1);
        check("irq_set", 16'(pc_irq), 16'h1);
        ack_cycle();
        check("flag_acked", 16'(pc_flag), 16'h0);

        // bit1 is not in PCMSK
        @(negedge clk);
        pin_in = 8'hFD;
        repeat (LAT + 2) @(posedge clk);
        #1 check("bit1_no_flag", 16'(pc_flag), 16'h0);
        check("bit1_rdata", 16'(rdata), 16'h7D);

        @(negedge clk);
        pin_in = 8'hFC;
        repeat (LAT + 1) @(posedge clk);
        #1 check("bit0_fall_flag", 16'(pc_flag), 16'h1);

        // ack coincides with a new change: set wins
        @(negedge clk);
        pin_in = 8'hFD;
        repeat (LAT) @(posedge clk);
        @(negedge clk);
        pc_ack = 1'b1;
        @(posedge clk);
        #1 check("ack_vs_chg", 16'(pc_flag), 16'h1);
        @(posedge clk);
        #1 check("ack_clear", 16'(pc_flag), 16'h0);
        pc_ack = 1'b0;

        // PCMSK cleared in the detect cycle: old mask still qualifies
        @(negedge clk);
        pin_in = 8'hFC;
        repeat (LAT) @(posedge clk);
        wr(2'd3, 8'h00);
        sel = 2'd3;
        #1 check("pcmsk_race_flag", 16'(pc_flag), 16'h1);
        check("pcmsk_race_rd", 16'(rdata), 16'h00);
        ack_cycle();
        check("pcmsk_race_ack", 16'(pc_flag), 16'h0);

        @(negedge clk);
        pin_in = 8'hFD;
        repeat (LAT + 2) @(posedge clk);
        #1 check("masked_chg", 16'(pc_flag), 16'h0);
        wr(2'd3, 8'h01);
        repeat (3) @(posedge clk);
        #1 check("no_retro_flag", 16'(pc_flag), 16'h0);

        // reset while a change is in flight
        wr(2'd1, 8'h11);
        wr(2'd2, 8'h42);
        @(negedge clk);
        pin_in = 8'hFC;
        repeat (LAT) @(posedge clk);
        @(negedge clk);
        nrst = 1'b0;
        sel  = 2'd3;
        #1;
        check("midrst_port", 16'(port_out), 16'h25);
        check("midrst_ddr", 16'(ddr_out), 16'h00);
        check("midrst_pcmsk", 16'(rdata), 16'h00);
        check("midrst_flag", 16'(pc_flag), 16'h0);
        @(negedge clk);
        nrst = 1'b1;
        repeat (LAT + 2) @(posedge clk);
        #1 check("midrst_lost", 16'(pc_flag), 16'h0);

`ifdef GPIO_PORT_FILTER_EN
        wr(2'd3, 8'h01);
        @(negedge clk);
        pin_in = 8'h00;
        sel    = 2'd0;
        repeat (LAT + 3) @(posedge clk);
        ack_cycle();
        check("filt_idle", 16'(pc_flag), 16'h0);

        @(negedge clk);
        pin_in = 8'h01;
        repeat (2) @(posedge clk);
        @(negedge clk);
        pin_in = 8'h00;
        repeat (8) @(posedge clk);
        #1 check("filt_glitch_pin", 16'(rdata[0]), 16'h0);
        check("filt_glitch_flag", 16'(pc_flag), 16'h0);

        @(negedge clk);
        pin_in = 8'h01;
        repeat (4) @(posedge clk);
        #1 check("filt_pulse_e4", 16'(rdata[0]), 16'h0);
        @(negedge clk);
        pin_in = 8'h00;
        @(posedge clk);
        #1 check("filt_pulse_e5", 16'(rdata[0]), 16'h1);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
